coax_transaction_sequencer: RTL and testbench
=============================================

Name: coax_transaction_sequencer

Overview:
Sequences one complete coax transaction (command out, response back) over the buffered TX and RX paths. It sits between the host control logic and coax_buffered_tx / coax_buffered_rx. It accepts command words over a valid/ready stream, loads and starts the TX buffer, waits for the line to go idle, and enforces a response timeout. It then streams received words back and reports a single completion status.

Parameters:
CLOCKS_PER_BIT, 16, coax bit period in clk cycles (used only to derive default timeout)
RESPONSE_TIMEOUT, 5 * 12 * CLOCKS_PER_BIT, clk cycles allowed from TX idle to rx_active rising
COUNTER_WIDTH, 16, width of timeout counter; must hold RESPONSE_TIMEOUT

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
abort  in  1  pulse; cancel current transaction
cmd_valid  in  1  command word valid
cmd_ready  out  1  command word accepted this cycle when cmd_valid && cmd_ready
cmd_data  in  10  command word
cmd_last  in  1  marks final command word
rsp_valid  out  1  response word valid
rsp_ready  in  1  consumer accepts response word
rsp_data  out  10  response word
busy  out  1  transaction in progress
done_strobe  out  1  one-cycle pulse at completion
status  out  2  0=OK, 1=TIMEOUT, 2=RX_ERROR, 3=ABORTED; held until next done_strobe
tx_reset  out  1  flush TX buffer
tx_data  out  10  word to TX buffer
tx_load_strobe  out  1  push tx_data
tx_start_strobe  out  1  start transmission
tx_full  in  1  TX buffer full
tx_active  in  1  TX line active
rx_reset  out  1  flush RX buffer
rx_active  in  1  RX receiving
rx_error  in  1  RX error (sticky until rx_reset)
rx_data  in  10  RX buffer head word, valid when !rx_empty
rx_read_strobe  out  1  pop RX head
rx_empty  in  1  RX buffer empty

Behaviour:
- Reset values: all outputs 0. State is IDLE. status=0.
- IDLE: cmd_ready=0. On the first cmd_valid, pulse rx_reset for 1 cycle (flush stale RX data), then go to LOAD. busy=1 from the cycle after cmd_valid is seen until the done_strobe cycle inclusive.
- LOAD:
  - cmd_ready = !tx_full.
  - On each accept: tx_load_strobe=1 and tx_data=cmd_data in the same cycle (combinational pass-through).
  - Accepting the word with cmd_last=1 goes to START.
- START: tx_start_strobe=1 for exactly 1 cycle, then go to WAIT_TX_ON.
- WAIT_TX_ON: wait for tx_active=1. Then go to WAIT_TX_OFF.
- WAIT_TX_OFF: on tx_active=0, clear the counter and go to WAIT_RX.
- WAIT_RX:
  - The counter increments each cycle.
  - rx_active=1 goes to RECEIVE.
  - rx_error=1 finishes with RX_ERROR.
  - Counter reaching RESPONSE_TIMEOUT-1 without rx_active finishes with TIMEOUT, i.e. exactly RESPONSE_TIMEOUT cycles after entry.
  - If rx_active and the timeout occur in the same cycle, rx_active wins.
- RECEIVE:
  - rsp_valid = !rx_empty && !pop_wait. rsp_data = rx_data.
  - On rsp_valid && rsp_ready: rx_read_strobe=1 for 1 cycle, then force rsp_valid=0 for 1 cycle (pop_wait) while rx_empty/rx_data update.
  - rx_error=1 at any point finishes with RX_ERROR. Words not yet consumed are discarded via rx_reset.
  - rx_active=0 && rx_empty=1 && !pop_wait finishes with OK.
- FINISH (1 cycle): done_strobe=1, status latched, busy=1. On non-OK status, also pulse rx_reset. Then go to IDLE.
- abort:
  - In any non-IDLE state, abort pulses tx_reset and rx_reset for 1 cycle and goes to FINISH with ABORTED. This takes priority over all other events that cycle.
  - In LOAD, cmd_ready=0 during the abort cycle.
  - abort in IDLE is ignored.
- No cmd_ready while not in LOAD; the consumer side never stalls TX.
- An empty transaction (cmd_last on the first word) is legal: one word sent.
- If tx_active never rises, the block stays in WAIT_TX_ON; abort is the only escape. This is intentional, because coax_buffered_tx always asserts active after start.
- Reset mid-transaction returns to IDLE with all outputs 0 next cycle. No done_strobe is issued.

Test Plan:
- 3 command words (0x001, 0x002, 0x003 last), TX model active 40 cycles, RX model delivers 0x2A5 then idle, rsp_ready=1 -> 3 tx_load_strobes with matching tx_data, 1 tx_start_strobe, rsp_data=0x2A5 once, done_strobe with status=0.
- Same command, RX never goes active, RESPONSE_TIMEOUT=960 -> done_strobe exactly 960 cycles after tx_active falls, status=1, rx_reset pulses at finish.
- tx_full held high 10 cycles during LOAD -> cmd_ready=0 and no tx_load_strobe for those cycles; all words still delivered in order.
- RX delivers 4 words, rsp_ready toggles every other cycle -> all 4 words in order, no duplicates, no rx_read_strobe on consecutive cycles, status=0.
- rx_error asserted after the 2nd response word -> done_strobe with status=2, rx_reset pulsed, no further rsp_valid.
- abort during WAIT_RX -> tx_reset and rx_reset pulse the same cycle, done_strobe the next cycle with status=3, busy=0 after that; a subsequent transaction completes with status=0.

Source files
------------

// File: rtl/coax_transaction_sequencer.sv
// coax_transaction_sequencer: runs one command/response coax transaction over buffered TX/RX paths
// Host side:  abort, cmd_valid/cmd_ready/cmd_data/cmd_last in, rsp_valid/rsp_ready/rsp_data out,
//             busy, done_strobe and status (0 OK, 1 TIMEOUT, 2 RX_ERROR, 3 ABORTED) out.
// TX buffer:  tx_reset, tx_data, tx_load_strobe, tx_start_strobe out; tx_full, tx_active in.
// RX buffer:  rx_reset, rx_read_strobe out; rx_active, rx_error, rx_data, rx_empty in.
module coax_transaction_sequencer #(
    parameter int CLOCKS_PER_BIT   = 16,
    parameter int RESPONSE_TIMEOUT = 5 * 12 * CLOCKS_PER_BIT,
    parameter int COUNTER_WIDTH    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       abort,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_data,
    input  logic       cmd_last,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [9:0] rsp_data,
    output logic       busy,
    output logic       done_strobe,
    output logic [1:0] status,
    output logic       tx_reset,
    output logic [9:0] tx_data,
    output logic       tx_load_strobe,
    output logic       tx_start_strobe,
    input  logic       tx_full,
    input  logic       tx_active,
    output logic       rx_reset,
    input  logic       rx_active,
    input  logic       rx_error,
    input  logic [9:0] rx_data,
    output logic       rx_read_strobe,
    input  logic       rx_empty
);
    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] LOAD        = 3'd1;
    localparam logic [2:0] START       = 3'd2;
    localparam logic [2:0] WAIT_TX_ON  = 3'd3;
    localparam logic [2:0] WAIT_TX_OFF = 3'd4;
    localparam logic [2:0] WAIT_RX     = 3'd5;
    localparam logic [2:0] RECEIVE     = 3'd6;
    localparam logic [2:0] FINISH      = 3'd7;
    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_TIMEOUT  = 2'd1;
    localparam logic [1:0] ST_RX_ERROR = 2'd2;
    localparam logic [1:0] ST_ABORTED  = 2'd3;
    localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST = COUNTER_WIDTH'(RESPONSE_TIMEOUT - 1);

    logic [2:0]               state;
    logic [COUNTER_WIDTH-1:0] count;
    logic                     pop_wait;
    logic                     kill;
    logic                     accept;

    // FINISH is already the completion cycle, so an abort there cannot start a second one
    assign kill            = abort && state != IDLE && state != FINISH;
    assign cmd_ready       = state == LOAD && !tx_full && !abort;
    assign accept          = cmd_valid && cmd_ready;
    assign tx_load_strobe  = accept;
    assign tx_data         = accept ? cmd_data : '0;
    assign tx_start_strobe = state == START && !abort;
    // pop_wait hides the stale head for the cycle the RX buffer needs after a pop
    assign rsp_valid       = state == RECEIVE && !rx_empty && !pop_wait && !rx_error && !abort;
    assign rsp_data        = rsp_valid ? rx_data : '0;
    assign rx_read_strobe  = rsp_valid && rsp_ready;
    assign busy            = state != IDLE;
    assign done_strobe     = state == FINISH;
    assign tx_reset        = kill;
    // aborts flush in the abort cycle itself, so FINISH only flushes for timeout/rx error
    assign rx_reset        = kill || (state == IDLE && cmd_valid) ||
                             (state == FINISH && (status == ST_TIMEOUT || status == ST_RX_ERROR));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            pop_wait <= 1'b0;
            status   <= ST_OK;
        end else if (kill) begin
            state    <= FINISH;
            status   <= ST_ABORTED;
            pop_wait <= 1'b0;
        end else begin
            pop_wait <= rx_read_strobe;
            case (state)
                IDLE:        if (cmd_valid) state <= LOAD;
                LOAD:        if (accept && cmd_last) state <= START;
                START:       state <= WAIT_TX_ON;
                WAIT_TX_ON:  if (tx_active) state <= WAIT_TX_OFF;
                WAIT_TX_OFF: if (!tx_active) begin
                    state <= WAIT_RX;
                    count <= '0;
                end
                WAIT_RX: begin
                    count <= count + 1'b1;
                    if (rx_active) begin
                        state <= RECEIVE;
                    end else if (rx_error) begin
                        state  <= FINISH;
                        status <= ST_RX_ERROR;
                    end else if (count == TIMEOUT_LAST) begin
                        state  <= FINISH;
                        status <= ST_TIMEOUT;
                    end
                end
                RECEIVE: begin
                    if (rx_error) begin
                        state  <= FINISH;
                        status <= ST_RX_ERROR;
                    end else if (!rx_active && rx_empty && !pop_wait) begin
                        state  <= FINISH;
                        status <= ST_OK;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_coax_transaction_sequencer.sv
// tb_coax_transaction_sequencer: directed + randomized transactions against TX/RX line models
module tb_coax_transaction_sequencer;
    localparam int T = 960;

    logic       clk = 1'b0;
    logic       reset, abort, cmd_valid, cmd_last, rsp_ready, tx_full, tx_active;
    logic       rx_active, rx_error, rx_empty;
    logic       cmd_ready, rsp_valid, busy, done_strobe, tx_reset, tx_load_strobe;
    logic       tx_start_strobe, rx_reset, rx_read_strobe;
    logic [9:0] cmd_data, rsp_data, tx_data, rx_data;
    logic [1:0] status;

    always #5 clk = ~clk;

    coax_transaction_sequencer dut (
        .clk(clk), .reset(reset), .abort(abort),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_last(cmd_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .done_strobe(done_strobe), .status(status),
        .tx_reset(tx_reset), .tx_data(tx_data), .tx_load_strobe(tx_load_strobe),
        .tx_start_strobe(tx_start_strobe), .tx_full(tx_full), .tx_active(tx_active),
        .rx_reset(rx_reset), .rx_active(rx_active), .rx_error(rx_error), .rx_data(rx_data),
        .rx_read_strobe(rx_read_strobe), .rx_empty(rx_empty)
    );

    int checks = 0, errors = 0, cyc = 0, txn_cyc = 0;
    logic [9:0] cmds[$], rx_words[$], rx_q[$], got_tx[$], got_rsp[$], exp_rsp[$];
    int  cmd_ptr, rx_ptr, tx_phase, tx_timer, tx_len, rx_phase, rx_timer;
    bit  rx_enable, err_reg, cmd_hold, prev_read;
    int  err_after, full_from, full_len, ready_mode, abort_k;
    int  starts, loads_bad, proto_bad, done_n, consec, ready_while_full, rx_resets;
    int  tx_low_cyc, done_cyc, last_rx_reset_cyc, last_tx_reset_cyc, abort_cyc;
    logic [1:0] done_status;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_words(input string tag, input logic [9:0] got[$], input logic [9:0] exp[$]);
        check({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    endtask

    task automatic drive();
        cmd_valid = cmd_ptr < cmds.size() && (cmd_ptr == 0 || cmd_hold || $urandom_range(3) != 0);
        cmd_data  = cmd_valid ? cmds[cmd_ptr] : 10'($urandom);
        cmd_last  = cmd_valid && cmd_ptr == cmds.size() - 1;
        tx_full   = full_len > 0 && txn_cyc >= full_from && txn_cyc < full_from + full_len;
        tx_active = tx_phase == 2;
        rx_active = rx_phase >= 2;
        rx_empty  = rx_q.size() == 0;
        rx_data   = rx_empty ? 10'h3FF : rx_q[0];
        rx_error  = err_reg;
        if (ready_mode == 0) rsp_ready = 1'b1;
        else if (ready_mode == 1) rsp_ready = txn_cyc % 2 == 0;
        else rsp_ready = 1'($urandom_range(1));
        abort = abort_k > 0 && tx_low_cyc >= 0 && cyc == tx_low_cyc + abort_k;
    endtask

    task automatic observe();
        if (tx_load_strobe !== (cmd_valid && cmd_ready)) loads_bad++;
        if (cmd_ready && tx_full) ready_while_full++;
        if ((rsp_valid || done_strobe) && !busy) proto_bad++;
        if (rsp_valid && err_reg) proto_bad++;
        cmd_hold = cmd_valid && !cmd_ready;
        if (cmd_valid && cmd_ready) begin
            got_tx.push_back(tx_data);
            cmd_ptr++;
        end
        if (abort) abort_cyc = cyc;
        if (rsp_valid && rsp_ready) got_rsp.push_back(rsp_data);
        if (rx_read_strobe && prev_read) consec++;
        prev_read = rx_read_strobe;
        if (rx_read_strobe && rx_q.size() > 0) void'(rx_q.pop_front());
        if (err_after >= 0 && got_rsp.size() == err_after) begin
            err_reg   = 1'b1;
            err_after = -1;
            rx_phase  = 0;
        end
        if (rx_reset) begin
            rx_resets++;
            last_rx_reset_cyc = cyc;
            rx_q.delete();
            err_reg = 1'b0;
        end
        if (done_strobe) begin
            done_n++;
            done_cyc    = cyc;
            done_status = status;
        end
        if (tx_phase == 2) begin
            tx_timer--;
            if (tx_timer == 0) begin
                tx_phase   = 0;
                tx_low_cyc = cyc + 1;
                if (rx_enable) begin
                    rx_phase = 1;
                    rx_timer = $urandom_range(5, 60);
                end
            end
        end else if (tx_phase == 1) begin
            tx_timer--;
            if (tx_timer == 0) begin
                tx_phase = 2;
                tx_timer = tx_len;
            end
        end
        if (tx_start_strobe) begin
            starts++;
            tx_phase = 1;
            tx_timer = $urandom_range(1, 4);
        end
        if (tx_reset) begin
            last_tx_reset_cyc = cyc;
            tx_phase = 0;
        end
        if (rx_phase == 1) begin
            rx_timer--;
            if (rx_timer == 0) begin
                rx_phase = 2;
                rx_timer = $urandom_range(1, 6);
            end
        end else if (rx_phase == 2) begin
            if (rx_ptr < rx_words.size()) begin
                rx_timer--;
                if (rx_timer == 0) begin
                    rx_q.push_back(rx_words[rx_ptr]);
                    rx_ptr++;
                    rx_timer = $urandom_range(1, 6);
                end
            end else begin
                rx_phase = 3;
                rx_timer = 3;
            end
        end else if (rx_phase == 3) begin
            rx_timer--;
            if (rx_timer == 0) rx_phase = 0;
        end
    endtask

    task automatic tick();
        drive();
        #1;
        observe();
        @(posedge clk);
        #1;
        cyc++;
        txn_cyc++;
    endtask

    task automatic start_txn();
        got_tx.delete(); got_rsp.delete(); rx_q.delete();
        cmd_ptr = 0; rx_ptr = 0; txn_cyc = 0; tx_phase = 0; rx_phase = 0;
        err_reg = 0; cmd_hold = 0; prev_read = 0;
        starts = 0; loads_bad = 0; proto_bad = 0; done_n = 0; consec = 0;
        ready_while_full = 0; rx_resets = 0;
        tx_low_cyc = -1; done_cyc = -1; last_rx_reset_cyc = -1; last_tx_reset_cyc = -1; abort_cyc = -1;
    endtask

    task automatic run_txn(input string tag, input logic [1:0] exp_status);
        start_txn();
        while (done_n == 0 && txn_cyc < 3000) tick();
        check({tag, "_done"}, done_n, 1);
        check({tag, "_status"}, done_status, exp_status);
        check_words({tag, "_tx"}, got_tx, cmds);
        check_words({tag, "_rsp"}, got_rsp, exp_rsp);
        check({tag, "_starts"}, starts, 1);
        check({tag, "_protocol"}, loads_bad + proto_bad + consec + ready_while_full, 0);
        drive();
        #1;
        check({tag, "_idle_after"}, {busy, done_strobe}, 0);
        observe();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic defaults();
        full_len = 0; full_from = 0; ready_mode = 0; err_after = -1; abort_k = 0;
        rx_enable = 1; tx_len = 40;
        cmds = '{10'h001, 10'h002, 10'h003};
        rx_words.delete();
        exp_rsp.delete();
    endtask

    initial begin
        defaults();
        cmds.delete();
        start_txn();
        reset = 1'b1;
        drive();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        drive();
        #1;
        check("reset_outputs", {busy, cmd_ready, rsp_valid, done_strobe, status, tx_reset, rx_reset,
                                tx_load_strobe, tx_start_strobe, rx_read_strobe, tx_data, rsp_data}, 0);
        @(posedge clk);
        #1;

        defaults();
        rx_words = '{10'h2A5};
        exp_rsp = rx_words;
        run_txn("basic", 2'd0);
        check("basic_rx_flush_once", rx_resets, 1);

        defaults();
        rx_enable = 0;
        run_txn("timeout", 2'd1);
        check("timeout_latency", done_cyc - (tx_low_cyc + 1), T);
        check("timeout_rx_reset_at_done", last_rx_reset_cyc, done_cyc);

        defaults();
        cmds.delete();
        for (int i = 0; i < 5; i++) cmds.push_back(10'($urandom));
        full_from = 2; full_len = 10;
        rx_words = '{10'h155};
        exp_rsp = rx_words;
        run_txn("txfull", 2'd0);

        defaults();
        rx_words = '{10'h101, 10'h202, 10'h303, 10'h0F0};
        exp_rsp = rx_words;
        ready_mode = 1;
        run_txn("toggle", 2'd0);

        defaults();
        rx_words = '{10'h011, 10'h022, 10'h033, 10'h044};
        exp_rsp = '{10'h011, 10'h022};
        err_after = 2;
        run_txn("rxerr", 2'd2);
        check("rxerr_rx_reset_at_done", last_rx_reset_cyc, done_cyc);

        defaults();
        rx_enable = 0;
        abort_k = 100;
        run_txn("abort", 2'd3);
        check("abort_tx_reset_cycle", last_tx_reset_cyc, abort_cyc);
        check("abort_rx_reset_cycle", last_rx_reset_cyc, abort_cyc);
        check("abort_done_next", done_cyc, abort_cyc + 1);

        defaults();
        rx_words = '{10'h3C3};
        exp_rsp = rx_words;
        run_txn("after_abort", 2'd0);

        defaults();
        cmds = '{10'h27E};
        rx_words = '{10'h1E1, 10'h2D2};
        exp_rsp = rx_words;
        run_txn("single", 2'd0);

        for (int t = 0; t < 6; t++) begin
            defaults();
            cmds.delete();
            for (int i = 0; i < $urandom_range(1, 6); i++) cmds.push_back(10'($urandom));
            for (int i = 0; i < $urandom_range(0, 5); i++) rx_words.push_back(10'($urandom));
            exp_rsp = rx_words;
            tx_len = $urandom_range(1, 50);
            ready_mode = 2;
            run_txn($sformatf("rand%0d", t), 2'd0);
        end

        defaults();
        start_txn();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cmds.delete();
        tx_phase = 0;
        drive();
        #1;
        check("midreset_outputs", {busy, cmd_ready, rsp_valid, done_strobe, status, tx_reset, rx_reset,
                                   tx_load_strobe, tx_start_strobe, rx_read_strobe, tx_data, rsp_data}, 0);
        check("midreset_no_done", done_n, 0);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
